// File: rtl/cpu_pkg.sv
// Shared constants and types for the five-stage pipeline front end.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

  // Action taken by the fetch stage on the last rising edge.
  localparam logic [1:0] IF_RUN      = 2'b00;
  localparam logic [1:0] IF_HOLD     = 2'b01;
  localparam logic [1:0] IF_BUBBLE   = 2'b10;
  localparam logic [1:0] IF_REDIRECT = 2'b11;

  // IF/ID pipeline register contents.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};

endpackage

// File: rtl/fetch_stage_pc_incr.sv
// Word-address incrementer: y = a + 1 over 30 bits, carry-out dropped.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   a  in  30  word address (PC[31:2])
//   y  out 30  a + 1 modulo 2^30
module pc_incr (
  input  logic [29:0] a,
  output logic [29:0] y
);

  // Ripple chain of half adders with the chain's carry-in tied high.
  logic [29:0] c;

  assign c[0] = 1'b1;

  for (genvar i = 0; i < 30; i++) begin : g_ha
    assign y[i] = a[i] ^ c[i];
    if (i < 29) begin : g_carry
      assign c[i+1] = a[i] & c[i];
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, IF/ID pipeline register, perf counters.
// Latency: imem_data in cycle n appears on IDinstr in cycle n+1.
// Backpressure: IDstall freezes PC and IF/ID; IFstall inserts bubbles; a taken branch overrides both.
//
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   IFstall, IDstall              stall requests from the stall unit
//   EXbr_taken, EXbr_target       resolved branch from EX
//   imem_addr / imem_data         instruction memory (async read)
//   IDinstr, IDpc4, IDvalid       IF/ID register outputs
//   IFstate                       action chosen on the previous edge
//   perf_fetch, perf_bubble       saturating activity counters
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             IFstall,
  input  logic             IDstall,
  input  logic             EXbr_taken,
  input  logic [31:0]      EXbr_target,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_data,
  output logic [31:0]      IDinstr,
  output logic [31:0]      IDpc4,
  output logic             IDvalid,
  output logic [1:0]       IFstate,
  output logic [CNT_W-1:0] perf_fetch,
  output logic [CNT_W-1:0] perf_bubble
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [31:0] pc;
  ifid_t       ifid;
  logic [29:0] pc_word_inc;
  logic [31:0] pc_plus4;
  logic [31:0] br_target_aligned;
  logic [1:0]  action;

  pc_incr u_pc_incr (
    .a (pc[31:2]),
    .y (pc_word_inc)
  );

  assign pc_plus4          = {pc_word_inc, 2'b00};
  assign br_target_aligned = EXbr_target & 32'hFFFF_FFFC;

  // Fixed priority: redirect beats data hazard beats branch-in-flight bubble.
  always_comb begin
    action = IF_RUN;
    if (EXbr_taken) begin
      action = IF_REDIRECT;
    end else if (IDstall) begin
      action = IF_HOLD;
    end else if (IFstall) begin
      action = IF_BUBBLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= RESET_PC;
      ifid        <= IFID_BUBBLE;
      IFstate     <= IF_RUN;
      perf_fetch  <= '0;
      perf_bubble <= '0;
    end else begin
      IFstate <= action;
      case (action)
        IF_REDIRECT: begin
          pc   <= br_target_aligned;
          ifid <= IFID_BUBBLE;
        end
        IF_HOLD: begin
          pc   <= pc;
          ifid <= ifid;
        end
        IF_BUBBLE: begin
          // PC stays at branch+4 so a not-taken branch needs no redirect.
          pc   <= pc;
          ifid <= IFID_BUBBLE;
        end
        default: begin
          pc   <= pc_plus4;
          ifid <= '{instr: imem_data, pc4: pc_plus4, valid: 1'b1};
        end
      endcase

      if (action == IF_RUN && perf_fetch != CNT_MAX) begin
        perf_fetch <= perf_fetch + CNT_ONE;
      end
      if ((action == IF_BUBBLE || action == IF_REDIRECT) && perf_bubble != CNT_MAX) begin
        perf_bubble <= perf_bubble + CNT_ONE;
      end
    end
  end

  assign imem_addr = pc;
  assign IDinstr   = ifid.instr;
  assign IDpc4     = ifid.pc4;
  assign IDvalid   = ifid.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, corner sequences, random run vs. model.
// Latency: n/a.
// Backpressure: n/a.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam int          MAXC   = 65535;

  logic        clk;
  logic        reset_n;
  logic        IFstall;
  logic        IDstall;
  logic        EXbr_taken;
  logic [31:0] EXbr_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] IDinstr;
  logic [31:0] IDpc4;
  logic        IDvalid;
  logic [1:0]  IFstate;
  logic [15:0] perf_fetch;
  logic [15:0] perf_bubble;

  fetch_stage #(.RESET_PC(RST_PC), .CNT_W(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .IFstall     (IFstall),
    .IDstall     (IDstall),
    .EXbr_taken  (EXbr_taken),
    .EXbr_target (EXbr_target),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .IDinstr     (IDinstr),
    .IDpc4       (IDpc4),
    .IDvalid     (IDvalid),
    .IFstate     (IFstate),
    .perf_fetch  (perf_fetch),
    .perf_bubble (perf_bubble)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: two fixed words, a hash elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h8C01_0004;
    if (a == 32'h0040_0004) return 32'h8C02_0008;
    return (a * 32'h9E37_79B1) ^ 32'h0000_1234;
  endfunction

  always_comb imem_data = mem_word(imem_addr);

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: architectural state after each edge.
  logic [31:0] m_pc, m_instr, m_pc4;
  bit          m_valid;
  logic [1:0]  m_state;
  int          m_fetch, m_bubble;

  function automatic void model_reset();
    m_pc = RST_PC; m_instr = 0; m_pc4 = 0; m_valid = 0; m_state = 2'b00;
    m_fetch = 0; m_bubble = 0;
  endfunction

  function automatic void model_edge(bit ifs, bit ids, bit br, logic [31:0] tgt);
    if (br) begin
      m_pc = {tgt[31:2], 2'b00};
      m_instr = 0; m_pc4 = 0; m_valid = 0; m_state = 2'b11;
      if (m_bubble < MAXC) m_bubble++;
    end else if (ids) begin
      m_state = 2'b01;
    end else if (ifs) begin
      m_instr = 0; m_pc4 = 0; m_valid = 0; m_state = 2'b10;
      if (m_bubble < MAXC) m_bubble++;
    end else begin
      m_instr = mem_word(m_pc);
      m_pc    = m_pc + 32'd4;
      m_pc4   = m_pc;
      m_valid = 1; m_state = 2'b00;
      if (m_fetch < MAXC) m_fetch++;
    end
  endfunction

  task automatic check_model(input string tag);
    check({tag, ".addr"},   imem_addr,            m_pc);
    check({tag, ".instr"},  IDinstr,              m_instr);
    check({tag, ".pc4"},    IDpc4,                m_pc4);
    check({tag, ".valid"},  {31'b0, IDvalid},     {31'b0, m_valid});
    check({tag, ".state"},  {30'b0, IFstate},     {30'b0, m_state});
    check({tag, ".fetch"},  {16'b0, perf_fetch},  32'(m_fetch));
    check({tag, ".bubble"}, {16'b0, perf_bubble}, 32'(m_bubble));
  endtask

  task automatic drive(input bit ifs, input bit ids, input bit br, input logic [31:0] tgt);
    IFstall = ifs; IDstall = ids; EXbr_taken = br; EXbr_target = tgt;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          ifs, ids, br;
    logic [31:0] tgt;
    logic [31:0] e_addr, e_instr, e_pc4;
    bit          e_valid;
    logic [1:0]  e_state;
    int          e_fetch, e_bubble;
  } vec_t;

  vec_t vt[15];

  initial begin
    // Directed sequence: fetch, hold, not-taken, taken, priority, wrap.
    vt[0]  = '{0,0,0,32'h0, 32'h0040_0004, 32'h8C01_0004, 32'h0040_0004, 1, 2'b00, 1, 0};
    vt[1]  = '{0,0,0,32'h0, 32'h0040_0008, 32'h8C02_0008, 32'h0040_0008, 1, 2'b00, 2, 0};
    vt[2]  = '{0,1,0,32'h0, 32'h0040_0008, 32'h8C02_0008, 32'h0040_0008, 1, 2'b01, 2, 0};
    vt[3]  = '{1,1,0,32'h0, 32'h0040_0008, 32'h8C02_0008, 32'h0040_0008, 1, 2'b01, 2, 0};
    vt[4]  = '{0,0,0,32'h0, 32'h0040_000C, mem_word(32'h0040_0008), 32'h0040_000C, 1, 2'b00, 3, 0};
    vt[5]  = '{0,0,0,32'h0, 32'h0040_0010, mem_word(32'h0040_000C), 32'h0040_0010, 1, 2'b00, 4, 0};
    vt[6]  = '{1,0,0,32'h0, 32'h0040_0010, 32'h0, 32'h0, 0, 2'b10, 4, 1};
    vt[7]  = '{1,0,0,32'h0, 32'h0040_0010, 32'h0, 32'h0, 0, 2'b10, 4, 2};
    vt[8]  = '{0,0,0,32'h0, 32'h0040_0014, mem_word(32'h0040_0010), 32'h0040_0014, 1, 2'b00, 5, 2};
    vt[9]  = '{1,0,0,32'h0, 32'h0040_0014, 32'h0, 32'h0, 0, 2'b10, 5, 3};
    vt[10] = '{1,0,1,32'h0040_0103, 32'h0040_0100, 32'h0, 32'h0, 0, 2'b11, 5, 4};
    vt[11] = '{0,0,0,32'h0, 32'h0040_0104, mem_word(32'h0040_0100), 32'h0040_0104, 1, 2'b00, 6, 4};
    vt[12] = '{1,1,1,32'h0040_0200, 32'h0040_0200, 32'h0, 32'h0, 0, 2'b11, 6, 5};
    vt[13] = '{0,0,1,32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 2'b11, 6, 6};
    vt[14] = '{0,0,0,32'h0, 32'h0000_0000, mem_word(32'hFFFF_FFFC), 32'h0000_0000, 1, 2'b00, 7, 6};

    reset_n = 1'b0;
    drive(0, 0, 0, 32'h0);
    #12;
    check("rst.addr",   imem_addr,            RST_PC);
    check("rst.valid",  {31'b0, IDvalid},     32'h0);
    check("rst.state",  {30'b0, IFstate},     32'h0);
    check("rst.fetch",  {16'b0, perf_fetch},  32'h0);
    check("rst.bubble", {16'b0, perf_bubble}, 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(vt[i].ifs, vt[i].ids, vt[i].br, vt[i].tgt);
      edge_step();
      check($sformatf("v%0d.addr", i),   imem_addr,            vt[i].e_addr);
      check($sformatf("v%0d.instr", i),  IDinstr,              vt[i].e_instr);
      check($sformatf("v%0d.pc4", i),    IDpc4,                vt[i].e_pc4);
      check($sformatf("v%0d.valid", i),  {31'b0, IDvalid},     {31'b0, vt[i].e_valid});
      check($sformatf("v%0d.state", i),  {30'b0, IFstate},     {30'b0, vt[i].e_state});
      check($sformatf("v%0d.fetch", i),  {16'b0, perf_fetch},  32'(vt[i].e_fetch));
      check($sformatf("v%0d.bubble", i), {16'b0, perf_bubble}, 32'(vt[i].e_bubble));
    end

    // Async reset in the middle of a HOLD cycle.
    drive(0, 1, 0, 32'h0);
    edge_step();
    #3 reset_n = 1'b0;
    #1;
    model_reset();
    check_model("arst");
    #2 reset_n = 1'b1;

    // Saturate the bubble counter.
    drive(1, 0, 0, 32'h0);
    for (int i = 0; i < MAXC; i++) begin
      model_edge(1, 0, 0, 32'h0);
      edge_step();
    end
    check("sat.bubble", {16'b0, perf_bubble}, 32'h0000_FFFF);
    model_edge(1, 0, 0, 32'h0);
    edge_step();
    check("sat.hold", {16'b0, perf_bubble}, 32'h0000_FFFF);
    check_model("sat");

    // Random traffic against the model.
    reset_n = 1'b0;
    #1;
    model_reset();
    check_model("rrst");
    #2 reset_n = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      bit ifs, ids, br;
      logic [31:0] tgt;
      ifs = ($urandom_range(0, 99) < 25);
      ids = ($urandom_range(0, 99) < 20);
      br  = ($urandom_range(0, 99) < 8);
      tgt = $urandom;
      drive(ifs, ids, br, tgt);
      model_edge(ifs, ids, br, tgt);
      edge_step();
      check_model($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
